// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM onto one byte-wide RAM port; 1/2/4-byte transfers run as byte cycles.
// Latency: a read returns data N+2 cycles after acceptance, and a write completes N+1 cycles after acceptance.
// Backpressure: a requester holds req until its one-cycle ready pulse. MEM wins ties, and nothing is accepted in DONE.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic                owner_mem;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          nbytes;
  logic [2:0]          cnt;
  logic [2:0]          rcnt;
  logic [31:0]         wdata_q;
  logic [31:0]         asm_q;
  logic                rd_vld;
  logic                cap_vld;

  logic                accept;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_n;
  logic                wr_last;
  logic                rd_last;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  always_comb begin
    accept   = (state == IDLE) && (mem_req || if_req);
    sel_we   = mem_req && mem_we;
    sel_addr = mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    if (!mem_req)               sel_n = 3'd4;
    else if (mem_size == 2'b00) sel_n = 3'd1;
    else if (mem_size == 2'b01) sel_n = 3'd2;
    else                        sel_n = 3'd4;
    wr_last  = (state == WRITE) && (cnt == nbytes);
    rd_last  = (state == READ) && cap_vld && (rcnt == nbytes - 3'd1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_we ? WRITE : READ;
      READ:    if (rd_last) state_nxt = DONE;
      WRITE:   if (wr_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cnt counts bytes already placed on the RAM bus.
  // rcnt counts bytes captured from ram_din, which trails the bus by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem <= 1'b0;
      base      <= '0;
      nbytes    <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      rd_vld    <= 1'b0;
      cap_vld   <= 1'b0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_vld   <= 1'b0;
          cap_vld  <= 1'b0;
          ram_addr <= '0;
          ram_wr   <= 1'b0;
          ram_dout <= '0;
          if (accept) begin
            owner_mem <= mem_req;
            base      <= sel_addr;
            nbytes    <= sel_n;
            wdata_q   <= sel_we ? mem_wdata : 32'd0;
            asm_q     <= '0;
            cnt       <= 3'd1;
            rcnt      <= '0;
            ram_addr  <= sel_addr;
            ram_wr    <= sel_we;
            ram_dout  <= sel_we ? mem_wdata[7:0] : 8'd0;
            rd_vld    <= ~sel_we;
          end
        end
        WRITE: begin
          if (cnt == nbytes) begin
            ram_addr <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
          end else begin
            ram_addr <= base + ADDR_W'(cnt);
            ram_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + 3'd1;
          end
        end
        READ: begin
          cap_vld <= rd_vld;
          if (cnt != nbytes) begin
            ram_addr <= base + ADDR_W'(cnt);
            cnt      <= cnt + 3'd1;
            rd_vld   <= 1'b1;
          end else begin
            ram_addr <= '0;
            rd_vld   <= 1'b0;
          end
          if (cap_vld) begin
            asm_q[{rcnt[1:0], 3'b000} +: 8] <= ram_din;
            rcnt <= rcnt + 3'd1;
          end
        end
        DONE: begin
          rd_vld   <= 1'b0;
          cap_vld  <= 1'b0;
          ram_addr <= '0;
          ram_wr   <= 1'b0;
          ram_dout <= '0;
        end
        default: begin
          rd_vld  <= 1'b0;
          cap_vld <= 1'b0;
        end
      endcase
    end
  end

  assign if_ready  = (state == DONE) && !owner_mem;
  assign mem_ready = (state == DONE) && owner_mem;
  assign if_data   = if_ready  ? asm_q : 32'd0;
  assign mem_rdata = mem_ready ? asm_q : 32'd0;

endmodule
